afe_spi_master: RTL and testbench

- Byte-level SPI master for the AFE4403 register interface.
- Serves the diag and register-control blocks, which supply one byte per request and consume received bytes.
- Sequences a 32-bit frame as four bytes: address, data[23:16], data[15:8], data[7:0].
- Drives SCLK/MOSI/STE and samples MISO; advertises frame position on data_part and strobes flash/spi_done per byte.

---
 rtl/afe_spi_pkg.sv | 30 +++
 rtl/afe_spi_sclk_gen.sv | 45 ++++
 rtl/afe_spi_master.sv | 133 +++++++++++++
 tb/tb_afe_spi_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_spi_pkg.sv
// Shared types for the AFE4403 SPI master.
// Frame position codes match the diag block's data_part encoding.
package afe_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam logic [1:0] PART_ADDR = 2'b00;
  localparam logic [1:0] PART_H    = 2'b01;
  localparam logic [1:0] PART_M    = 2'b10;
  localparam logic [1:0] PART_L    = 2'b11;

  function automatic logic [1:0] next_part(input logic [1:0] p);
    logic [1:0] n;
    unique case (p)
      PART_ADDR: n = PART_H;
      PART_H:    n = PART_M;
      PART_M:    n = PART_L;
      default:   n = PART_ADDR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/afe_spi_sclk_gen.sv
// Mode-0 SCLK generator: HALF_DIV cycles per phase, idles low.
// Rise/fall strobes mark the cycle whose closing edge toggles SCLK.
module afe_spi_sclk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic div_clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int HW = $clog2(HALF_DIV + 1);
  localparam logic [HW-1:0] HLAST = HW'(HALF_DIV - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          sclk_q, sclk_d;
  logic          tog;

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      sclk_q <= sclk_d;
    end
  end

  always_comb begin
    tog    = en && (hcnt_q == HLAST);
    hcnt_d = '0;
    sclk_d = 1'b0;
    if (en) begin
      hcnt_d = tog ? '0 : hcnt_q + HW'(1);
      sclk_d = tog ? ~sclk_q : sclk_q;
    end
  end

  assign sclk      = sclk_q;
  assign sclk_rise = tog & ~sclk_q;
  assign sclk_fall = tog & sclk_q;

endmodule

// File: rtl/afe_spi_master.sv
// Byte-sequenced SPI master for the AFE4403 register port.
// One frame = addr, data[23:16], data[15:8], data[7:0].
module afe_spi_master
  import afe_spi_pkg::*;
#(
  parameter int HALF_DIV = 2,
  parameter int STE_GAP  = 4
) (
  input  logic       div_clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] tx_data,
  output logic       flash,
  output logic [1:0] data_part,
  output logic       spi_done,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_ste,
  input  logic       spi_miso
);

  localparam int GW = $clog2(STE_GAP + 1);
  localparam logic [GW-1:0] GLAST = GW'(STE_GAP - 1);

  state_e        state_q, state_d;
  logic [1:0]    part_q, part_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;

  logic sclk_en;
  logic sclk_rise;
  logic sclk_fall;
  logic last_fall;

  assign sclk_en   = (state_q == ST_SHIFT);
  assign last_fall = sclk_fall && (bit_q == 3'd7);

  afe_spi_sclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sclk (
    .div_clk  (div_clk),
    .rst      (rst),
    .en       (sclk_en),
    .sclk     (spi_sclk),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      part_q  <= PART_ADDR;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (wr_en | rd_en) state_d = ST_REQ;
      ST_REQ:   state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_d = ST_DONE;
      ST_DONE: begin
        // The IDLE cycle is the last STE-high cycle of the gap
        if (part_q != PART_L) state_d = ST_REQ;
        else if (STE_GAP > 1) state_d = ST_GAP;
        else                  state_d = ST_IDLE;
      end
      ST_GAP:   if (gap_q == GLAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    part_d  = part_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_LOAD: begin
        tx_sh_d = tx_data;
        bit_d   = 3'd0;
      end
      ST_SHIFT: begin
        if (sclk_rise) rx_sh_d = {rx_sh_q[6:0], spi_miso};
        if (sclk_fall) begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
        end
        if (last_fall) rx_d = rx_sh_q;
      end
      ST_DONE: begin
        part_d = next_part(part_q);
        gap_d  = GW'(1);
      end
      ST_GAP:  gap_d = gap_q + GW'(1);
      default: ;
    endcase
  end

  always_comb begin
    flash    = (state_q == ST_REQ);
    spi_done = (state_q == ST_DONE);
    busy     = (state_q != ST_IDLE);
    spi_ste  = (state_q == ST_IDLE) || (state_q == ST_GAP);
  end

  assign data_part = part_q;
  assign rx_data   = rx_q;
  assign spi_mosi  = tx_sh_q[7];

endmodule

// File: tb/tb_afe_spi_master.sv
// Directed bench for afe_spi_master: HALF_DIV=2/STE_GAP=4 main
// instance plus a HALF_DIV=1/STE_GAP=1 instance for fast timing.
module tb_afe_spi_master;

  localparam int STE_GAP = 4;

  logic       clk;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] tx_data;
  logic       flash, done, busy, sclk, mosi, ste, miso;
  logic [1:0] part;
  logic [7:0] rx;

  logic       f_wr;
  logic [7:0] f_tx;
  logic       f_flash, f_done, f_busy, f_sclk, f_mosi, f_ste, f_miso;
  logic [1:0] f_part;
  logic [7:0] f_rx;

  logic       loop_mode, glitch_mode;
  logic [7:0] tx_tab [4];
  logic [7:0] sl_tab [4];
  logic [7:0] sl_sh;
  logic [7:0] rx_log [4];
  logic [1:0] part_log [4];
  logic [31:0] mosi_word;
  logic       prev_flash, prev_sclk, prev_mosi;
  logic       f_prev_sclk, f_prev_mosi;

  int n_chk, n_pass, n_fail;
  int cyc_n, n_flash, n_done, ste_low, mosi_viol, last_done_cyc;
  int f_rises, f_per2, f_last_rise, f_viol, f_ste_low, f_done_n, f_flash_n;

  assign miso   = loop_mode ? mosi : sl_sh[7];
  assign f_miso = f_mosi;

  afe_spi_master #(.HALF_DIV(2), .STE_GAP(STE_GAP)) u_dut (
    .div_clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .tx_data(tx_data), .flash(flash), .data_part(part),
    .spi_done(done), .rx_data(rx), .busy(busy),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_ste(ste),
    .spi_miso(miso)
  );

  afe_spi_master #(.HALF_DIV(1), .STE_GAP(1)) u_fast (
    .div_clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(1'b0),
    .tx_data(f_tx), .flash(f_flash), .data_part(f_part),
    .spi_done(f_done), .rx_data(f_rx), .busy(f_busy),
    .spi_sclk(f_sclk), .spi_mosi(f_mosi), .spi_ste(f_ste),
    .spi_miso(f_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_mon();
    n_flash   = 0;
    n_done    = 0;
    ste_low   = 0;
    mosi_word = '0;
    for (int i = 0; i < 4; i++) begin
      rx_log[i]   = '0;
      part_log[i] = '0;
    end
    prev_flash = flash;
    prev_sclk  = sclk;
    prev_mosi  = mosi;
  endtask

  // Client + slave + monitor for the main instance, one cycle per call
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (prev_flash) begin
      tx_data = tx_tab[part];
      sl_sh   = sl_tab[part];
    end else if (glitch_mode) begin
      tx_data = 8'($urandom);
    end
    if (prev_sclk && !sclk) sl_sh = {sl_sh[6:0], 1'b0};
    if (!prev_sclk && sclk) mosi_word = {mosi_word[30:0], mosi};
    if (sclk && (mosi !== prev_mosi)) mosi_viol++;
    if (flash) n_flash++;
    if (done) begin
      rx_log[n_done[1:0]]   = rx;
      part_log[n_done[1:0]] = part;
      n_done++;
      last_done_cyc = cyc_n;
    end
    if (!ste) ste_low++;
    prev_flash = flash;
    prev_sclk  = sclk;
    prev_mosi  = mosi;
  endtask

  task automatic fcyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (!f_prev_sclk && f_sclk) begin
      f_rises++;
      if (cyc_n - f_last_rise == 2) f_per2++;
      f_last_rise = cyc_n;
    end
    if (f_sclk && (f_mosi !== f_prev_mosi)) f_viol++;
    if (!f_ste) f_ste_low++;
    if (f_done) f_done_n++;
    if (f_flash) f_flash_n++;
    f_prev_sclk = f_sclk;
    f_prev_mosi = f_mosi;
  endtask

  task automatic run_to_ste_high(input string tag);
    int k;
    k = 0;
    while (!ste && k < 400) begin
      cyc();
      k++;
    end
    chk(tag, 32'(k < 400), 32'd1);
  endtask

  task automatic pulse_wr();
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    int k, d_cyc, hi, nd;
    n_chk = 0; n_pass = 0; n_fail = 0;
    cyc_n = 0; mosi_viol = 0; last_done_cyc = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; tx_data = 8'h00;
    f_wr = 1'b0; f_tx = 8'hC3;
    loop_mode = 1'b1; glitch_mode = 1'b0; sl_sh = '0;
    for (int i = 0; i < 4; i++) begin
      tx_tab[i] = '0;
      sl_tab[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ste", 32'(ste), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_part", 32'(part), 32'd0);
    chk("rst_rx", 32'(rx), 32'd0);
    chk("rst_mosi_flash_done", 32'({mosi, flash, done}), 32'd0);
    rst = 1'b0;
    reset_mon();
    cyc();
    cyc();
    chk("idle_no_req", 32'({busy, ste}), 32'b01);

    // Single write frame, loopback
    reset_mon();
    tx_tab = '{8'h00, 8'h00, 8'h00, 8'h05};
    pulse_wr();
    chk("t1_req", 32'({flash, ste, busy}), 32'b101);
    run_to_ste_high("t1_timeout");
    chk("t1_ste_low", ste_low, 140);
    chk("t1_flash_n", n_flash, 4);
    chk("t1_done_n", n_done, 4);
    chk("t1_mosi", mosi_word, 32'h0000_0005);
    chk("t1_rx", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]},
        32'h0000_0005);
    chk("t1_gap_busy", 32'({busy, sclk}), 32'b10);
    k = 0;
    while (busy && k < 20) begin
      cyc();
      k++;
    end
    chk("t1_idle", 32'(busy), 32'd0);

    // Read frame with slave model
    reset_mon();
    loop_mode = 1'b0;
    tx_tab = '{8'h30, 8'h00, 8'h00, 8'h00};
    sl_tab = '{8'h00, 8'hA5, 8'h3C, 8'h0F};
    rd_en = 1'b1;
    cyc();
    cyc();
    rd_en = 1'b0;
    run_to_ste_high("t2_timeout");
    chk("t2_rx", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]},
        32'h00A5_3C0F);
    chk("t2_part", 32'({part_log[0], part_log[1], part_log[2],
                        part_log[3]}), 32'h1B);
    chk("t2_mosi", mosi_word, 32'h3000_0000);
    k = 0;
    while (busy && k < 20) begin
      cyc();
      k++;
    end

    // Back-to-back frames with wr_en held
    reset_mon();
    loop_mode = 1'b1;
    tx_tab = '{8'h81, 8'h42, 8'h24, 8'h18};
    wr_en = 1'b1;
    k = 0;
    while (n_done < 4 && k < 400) begin
      cyc();
      k++;
    end
    chk("t3_done_n", n_done, 4);
    chk("t3_mosi", mosi_word, 32'h8142_2418);
    d_cyc = last_done_cyc;
    hi = 0;
    k = 0;
    do begin
      cyc();
      if (ste) hi++;
      k++;
    end while (!flash && k < 20);
    chk("t3_req_delay", cyc_n - d_cyc, STE_GAP + 1);
    chk("t3_ste_high", hi, STE_GAP);
    wr_en = 1'b0;

    // Reset during byte 2 of the second frame
    k = 0;
    while (!(part == 2'd2 && sclk) && k < 300) begin
      cyc();
      k++;
    end
    chk("t4_reach", 32'(k < 300), 32'd1);
    nd = n_done;
    rst = 1'b1;
    #1;
    chk("t4_rst_ste_sclk", 32'({ste, sclk}), 32'b10);
    chk("t4_rst_part", 32'(part), 32'd0);
    cyc();
    cyc();
    chk("t4_no_done", n_done, nd);
    rst = 1'b0;
    cyc();
    reset_mon();
    tx_tab = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulse_wr();
    chk("t4_restart", 32'({flash, part}), 32'b100);
    run_to_ste_high("t4_timeout");
    chk("t4_part", 32'({part_log[0], part_log[1], part_log[2],
                        part_log[3]}), 32'h1B);
    chk("t4_rx", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]},
        32'h0102_0304);
    k = 0;
    while (busy && k < 20) begin
      cyc();
      k++;
    end

    // tx_data scrambled outside LOAD
    reset_mon();
    glitch_mode = 1'b1;
    tx_tab = '{8'h12, 8'h34, 8'h56, 8'h78};
    pulse_wr();
    run_to_ste_high("t5_timeout");
    chk("t5_mosi", mosi_word, 32'h1234_5678);
    chk("t5_rx", {rx_log[0], rx_log[1], rx_log[2], rx_log[3]},
        32'h1234_5678);
    glitch_mode = 1'b0;
    chk("mosi_stable_hi", mosi_viol, 0);

    // HALF_DIV=1, STE_GAP=1 instance, wr held for back-to-back
    f_rises = 0; f_per2 = 0; f_last_rise = -100; f_viol = 0;
    f_ste_low = 0; f_done_n = 0; f_flash_n = 0;
    f_prev_sclk = f_sclk; f_prev_mosi = f_mosi;
    f_wr = 1'b1;
    k = 0;
    while (f_done_n < 4 && k < 200) begin
      fcyc();
      k++;
    end
    chk("f_done_n", f_done_n, 4);
    chk("f_ste_low", f_ste_low, 76);
    chk("f_rises", f_rises, 32);
    chk("f_period2", f_per2, 28);
    chk("f_flash_n", f_flash_n, 4);
    chk("f_rx", 32'(f_rx), 32'hC3);
    hi = 0;
    k = 0;
    do begin
      fcyc();
      if (f_ste) hi++;
      k++;
    end while (f_ste && k < 20);
    chk("f_ste_gap", hi, 1);
    chk("f_restart_part", 32'(f_part), 32'd0);
    f_wr = 1'b0;
    k = 0;
    while (f_busy && k < 200) begin
      fcyc();
      k++;
    end
    chk("f_idle", 32'(f_busy), 32'd0);
    chk("f_mosi_stable_hi", f_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
